// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, capture state enum, counter helper
package vga_pkg;

    localparam int H_TOTAL      = 800;
    localparam int H_SYNC_END   = 96;
    localparam int H_SHOW_START = 144;
    localparam int V_TOTAL      = 525;
    localparam int V_SYNC_END   = 2;
    localparam int V_SHOW_START = 35;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Position counters stick at their maximum instead of wrapping, so a
    // missing sync pulse can never alias back onto a legal position.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_timing_tracker.sv
// rtl/vga_timing_tracker.sv - sync edge detection, pixel/line position recovery and timing checks
module vga_timing_tracker #(
    parameter int H_TOTAL    = vga_pkg::H_TOTAL,
    parameter int H_SYNC_END = vga_pkg::H_SYNC_END,
    parameter int V_TOTAL    = vga_pkg::V_TOTAL,
    parameter int V_SYNC_END = vga_pkg::V_SYNC_END
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       h_sync,
    input  logic       v_sync,
    output logic [9:0] h_idx,
    output logic [9:0] v_idx,
    output logic       frame_start,
    output logic       violation
);
    import vga_pkg::*;

    localparam logic [9:0] H_TOTAL_C    = 10'(H_TOTAL);
    localparam logic [9:0] H_SYNC_C     = 10'(H_SYNC_END);
    localparam logic [9:0] V_LAST_C     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SYNC_C     = 10'(V_SYNC_END);

    logic       hs_q, hs_d;
    logic       vs_line_q, vs_line_d;
    logic       vs_wait_q, vs_wait_d;
    logic [9:0] h_pos_q, h_pos_d;
    logic [9:0] v_idx_q, v_idx_d;
    logic       line_start;
    logic       hs_rise;

    // Recover the current position and flag any sync edge that lands off its nominal index.
    always_comb begin
        line_start  = !h_sync && hs_q;
        hs_rise     = h_sync && !hs_q;
        frame_start = line_start && !v_sync && vs_line_q;
        h_idx       = line_start ? 10'd0 : h_pos_q;
        h_pos_d     = line_start ? 10'd1 : sat_inc(h_pos_q);
        hs_d        = h_sync;
        v_idx_d     = v_idx_q;
        vs_line_d   = vs_line_q;
        vs_wait_d   = vs_wait_q;
        violation   = 1'b0;
        if (line_start) begin
            v_idx_d   = frame_start ? 10'd0 : sat_inc(v_idx_q);
            vs_line_d = v_sync;
            if (h_pos_q != H_TOTAL_C) begin
                violation = 1'b1;
            end
            if (frame_start) begin
                // Arm the vsync-width check for the first line that sees vsync released.
                vs_wait_d = 1'b1;
                if (v_idx_q != V_LAST_C) begin
                    violation = 1'b1;
                end
            end else if (v_sync && vs_wait_q) begin
                vs_wait_d = 1'b0;
                if (v_idx_d != V_SYNC_C) begin
                    violation = 1'b1;
                end
            end
        end
        if (hs_rise && (h_idx != H_SYNC_C)) begin
            violation = 1'b1;
        end
        v_idx = line_start ? v_idx_d : v_idx_q;
    end

    // Sync history and position counters; syncs idle high after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q      <= 1'b1;
            vs_line_q <= 1'b1;
            vs_wait_q <= 1'b0;
            h_pos_q   <= 10'd0;
            v_idx_q   <= 10'd0;
        end else begin
            hs_q      <= hs_d;
            vs_line_q <= vs_line_d;
            vs_wait_q <= vs_wait_d;
            h_pos_q   <= h_pos_d;
            v_idx_q   <= v_idx_d;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA stream capture: lock FSM and windowed frame-buffer writer
module vga_capture #(
    parameter int H_TOTAL      = vga_pkg::H_TOTAL,
    parameter int H_SYNC_END   = vga_pkg::H_SYNC_END,
    parameter int H_SHOW_START = vga_pkg::H_SHOW_START,
    parameter int V_TOTAL      = vga_pkg::V_TOTAL,
    parameter int V_SYNC_END   = vga_pkg::V_SYNC_END,
    parameter int V_SHOW_START = vga_pkg::V_SHOW_START,
    parameter int WIN_W        = 300,
    parameter int WIN_H        = 200,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        locked,
    output logic        frame_start,
    output logic        err
);
    import vga_pkg::*;

    localparam logic [9:0]  H_SHOW_C = 10'(H_SHOW_START);
    localparam logic [9:0]  V_SHOW_C = 10'(V_SHOW_START);
    localparam logic [9:0]  WIN_W_X  = 10'(WIN_W);
    localparam logic [9:0]  WIN_H_Y  = 10'(WIN_H);
    localparam logic [15:0] WIN_W_C  = 16'(WIN_W);
    localparam logic [7:0]  LOCK_C   = 8'(LOCK_FRAMES);

    logic [9:0]  h_idx, v_idx;
    logic        fs_ev, viol_raw, viol, in_win;
    logic [9:0]  x, y;
    state_e      state_q, state_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [11:0] wr_data_q, wr_data_d;
    logic        locked_q, locked_d;
    logic        frame_start_q, frame_start_d;
    logic        err_q, err_d;

    vga_timing_tracker #(
        .H_TOTAL    (H_TOTAL),
        .H_SYNC_END (H_SYNC_END),
        .V_TOTAL    (V_TOTAL),
        .V_SYNC_END (V_SYNC_END)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .h_idx       (h_idx),
        .v_idx       (v_idx),
        .frame_start (fs_ev),
        .violation   (viol_raw)
    );

    // Lock state: search for a frame start, then demand LOCK_FRAMES clean frames.
    always_comb begin
        viol       = viol_raw && (state_q != ST_SEARCH);
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        case (state_q)
            ST_SEARCH: begin
                if (fs_ev) begin
                    state_d    = ST_CHECK;
                    good_cnt_d = 8'd0;
                end
            end
            ST_CHECK: begin
                if (viol) begin
                    state_d = ST_SEARCH;
                end else if (fs_ev) begin
                    good_cnt_d = good_cnt_q + 8'd1;
                    if (good_cnt_d == LOCK_C) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (viol) begin
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Window compare and row-major address; a violating sample is never written.
    always_comb begin
        x             = h_idx - H_SHOW_C;
        y             = v_idx - V_SHOW_C;
        in_win        = (h_idx >= H_SHOW_C) && (x < WIN_W_X) &&
                        (v_idx >= V_SHOW_C) && (y < WIN_H_Y);
        wr_en_d       = (state_q == ST_LOCKED) && !viol && in_win;
        wr_addr_d     = wr_en_d ? (16'(y) * WIN_W_C) + 16'(x) : wr_addr_q;
        wr_data_d     = wr_en_d ? {r, g, b} : wr_data_q;
        locked_d      = (state_d == ST_LOCKED);
        frame_start_d = fs_ev;
        err_d         = viol;
    end

    // FSM state and every output are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SEARCH;
            good_cnt_q    <= 8'd0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= 16'd0;
            wr_data_q     <= 12'd0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            err_q         <= err_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign err         = err_q;

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - frame-level vector table plus reset and pixel-data sequences for vga_capture
module tb_vga_capture;

    localparam int H_T  = 40;
    localparam int H_S  = 6;
    localparam int H_SH = 10;
    localparam int V_T  = 30;
    localparam int V_S  = 2;
    localparam int V_SH = 5;
    localparam int W_W  = 12;
    localparam int W_H  = 8;
    localparam int FULL = W_W * W_H;

    localparam int K_NOM    = 0;
    localparam int K_LONG   = 1;
    localparam int K_HSHORT = 2;
    localparam int K_VS3    = 3;

    typedef struct {
        int kind;
        int exp_wr;
        int exp_err;
        int exp_fs;
        int exp_locked;
    } frame_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        h_sync, v_sync;
    logic [3:0]  r, g, b;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [11:0] wr_data;
    logic        locked, frame_start, err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int tot_wr = 0, tot_err = 0, tot_fs = 0, tot_bad_order = 0, tot_bad_data = 0;
    int fs_cyc = -1, lock_cyc = -2, first_wr_cyc = -1, gen_first_cyc = -3;
    int first_addr = -1, last_addr = -1, exp_addr = 0;
    bit fresh = 1'b0, locked_prev = 1'b0;
    int mx, my;
    logic [11:0] exp_d;
    logic [11:0] mem [FULL];

    frame_vec_t tbl [14];
    frame_vec_t post_rst [3];

    vga_capture #(
        .H_TOTAL      (H_T),
        .H_SYNC_END   (H_S),
        .H_SHOW_START (H_SH),
        .V_TOTAL      (V_T),
        .V_SYNC_END   (V_S),
        .V_SHOW_START (V_SH),
        .WIN_W        (W_W),
        .WIN_H        (W_H),
        .LOCK_FRAMES  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .r           (r),
        .g           (g),
        .b           (b),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .locked      (locked),
        .frame_start (frame_start),
        .err         (err)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: accumulates event counts, write order and data against the pattern model.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_addr = 0;
        end else begin
            if (frame_start) begin
                tot_fs++;
                fs_cyc   = cyc;
                exp_addr = 0;
                fresh    = 1'b1;
            end
            if (err) tot_err++;
            if (locked && !locked_prev) lock_cyc = cyc;
            locked_prev = locked;
            if (wr_en) begin
                tot_wr++;
                if (fresh) begin
                    first_addr   = int'(wr_addr);
                    first_wr_cyc = cyc;
                    fresh        = 1'b0;
                end
                last_addr = int'(wr_addr);
                if (int'(wr_addr) != exp_addr) tot_bad_order++;
                mx    = int'(wr_addr) % W_W;
                my    = int'(wr_addr) / W_W;
                exp_d = {mx[3:0], my[3:0], 4'hA};
                if (wr_data !== exp_d) tot_bad_data++;
                if (int'(wr_addr) < FULL) mem[wr_addr] = wr_data;
                exp_addr = exp_addr + 1;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives one frame; stops before pixel (stop_line, stop_pix) when stop_line >= 0.
    task automatic run_frame(input int kind, input int stop_line, input int stop_pix);
        int len, hs_len, vs_len, xx, yy;
        for (int v = 0; v < V_T; v++) begin
            len    = (kind == K_LONG && v == 8) ? H_T + 1 : H_T;
            hs_len = (kind == K_HSHORT && v == 8) ? H_S - 1 : H_S;
            vs_len = (kind == K_VS3) ? 3 : V_S;
            for (int h = 0; h < len; h++) begin
                if (v == stop_line && h == stop_pix) return;
                @(posedge clk);
                #1;
                h_sync = (h >= hs_len);
                v_sync = (v >= vs_len);
                if (h >= H_SH && v >= V_SH) begin
                    xx = h - H_SH;
                    yy = v - V_SH;
                    r  = xx[3:0];
                    g  = yy[3:0];
                    b  = 4'hA;
                end else begin
                    r = 4'h0;
                    g = 4'h0;
                    b = 4'h0;
                end
                if (v == V_SH && h == H_SH) gen_first_cyc = cyc;
            end
        end
    endtask

    task automatic apply_vec(input frame_vec_t fv, input string tag);
        int s_wr, s_err, s_fs, s_bo, s_bd;
        bit was_locked;
        s_wr = tot_wr; s_err = tot_err; s_fs = tot_fs;
        s_bo = tot_bad_order; s_bd = tot_bad_data;
        was_locked = locked;
        run_frame(fv.kind, -1, 0);
        check({tag, "_writes"}, tot_wr - s_wr, fv.exp_wr);
        check({tag, "_err"}, tot_err - s_err, fv.exp_err);
        check({tag, "_frame_start"}, tot_fs - s_fs, fv.exp_fs);
        check({tag, "_locked"}, locked, fv.exp_locked);
        check({tag, "_addr_order"}, tot_bad_order - s_bo, 0);
        check({tag, "_data"}, tot_bad_data - s_bd, 0);
        if (fv.exp_wr > 0) begin
            check({tag, "_first_addr"}, first_addr, 0);
            check({tag, "_last_addr"}, last_addr, fv.exp_wr - 1);
            check({tag, "_first_wr_latency"}, first_wr_cyc, gen_first_cyc + 1);
        end
        if (fv.exp_locked != 0 && !was_locked) begin
            check({tag, "_lock_vs_frame_start"}, lock_cyc, fs_cyc);
        end
    endtask

    initial begin
        tbl[0]  = '{K_NOM,    0,    0, 1, 0};
        tbl[1]  = '{K_NOM,    0,    0, 1, 0};
        tbl[2]  = '{K_NOM,    FULL, 0, 1, 1};
        tbl[3]  = '{K_NOM,    FULL, 0, 1, 1};
        tbl[4]  = '{K_LONG,   48,   1, 1, 0};
        tbl[5]  = '{K_NOM,    0,    0, 1, 0};
        tbl[6]  = '{K_NOM,    0,    0, 1, 0};
        tbl[7]  = '{K_NOM,    FULL, 0, 1, 1};
        tbl[8]  = '{K_VS3,    0,    1, 1, 0};
        tbl[9]  = '{K_NOM,    0,    0, 1, 0};
        tbl[10] = '{K_HSHORT, 0,    1, 1, 0};
        tbl[11] = '{K_NOM,    0,    0, 1, 0};
        tbl[12] = '{K_NOM,    0,    0, 1, 0};
        tbl[13] = '{K_NOM,    FULL, 0, 1, 1};
        post_rst[0] = '{K_NOM, 0,    0, 1, 0};
        post_rst[1] = '{K_NOM, 0,    0, 1, 0};
        post_rst[2] = '{K_NOM, FULL, 0, 1, 1};

        rst = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
        r = 4'h0; g = 4'h0; b = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wr_en", wr_en, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_data", wr_data, 0);
        check("reset_locked", locked, 0);
        check("reset_frame_start", frame_start, 0);
        check("reset_err", err, 0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply_vec(tbl[i], $sformatf("frame%0d", i + 1));
        end

        check("pattern_addr13", mem[13], 12'h11A);
        check("pattern_addr95", mem[95], 12'hB7A);

        run_frame(K_NOM, 7, H_SH + 5);
        check("pre_rst_wr_en", wr_en, 1);
        check("pre_rst_locked", locked, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_wr_en", wr_en, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_locked", locked, 0);
        check("midrst_frame_start", frame_start, 0);
        check("midrst_err", err, 0);

        for (int i = 0; i < 3; i++) begin
            apply_vec(post_rst[i], $sformatf("relock%0d", i + 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
